i2c_target_rx: RTL

I2C_TARGET_RX -- requirements
Module: i2c_target_rx

---
 rtl/i2c_pkg.sv | 31 +++
 rtl/i2c_target_rx_if.sv | 27 ++
 rtl/i2c_sync_edge.sv | 65 ++++++
 rtl/i2c_target_rx.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | i2c_pkg : shared state enumeration, address width and helpers        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package i2c_pkg;

  localparam int I2C_ADDR_W = 7;
  localparam logic [I2C_ADDR_W-1:0] I2C_DEFAULT_ADDR = 7'h50;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ADDR     = 3'd1,
    ADDR_ACK = 3'd2,
    DATA     = 3'd3,
    DATA_ACK = 3'd4,
    IGNORE   = 3'd5
  } i2c_state_e;

  function automatic logic maj3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

  // Address byte is {addr[6:0], R/W}; only writes to our address are accepted.
  function automatic logic addr_write_hit(input logic [7:0] b,
                                          input logic [I2C_ADDR_W-1:0] dev);
    return (b[7:1] == dev) && !b[0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/i2c_target_rx_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | i2c_target_rx_if : I2C bus pins and receive-side status of the target|
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface i2c_target_rx_if;

  logic       scl;
  logic       sda_in;
  logic       sda_oe;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       addr_hit;
  logic       busy;

  modport master (
    output scl, sda_in,
    input  sda_oe, rx_data, rx_valid, addr_hit, busy
  );

  modport slave (
    input  scl, sda_in,
    output sda_oe, rx_data, rx_valid, addr_hit, busy
  );

endinterface
`default_nettype wire

// File: rtl/i2c_sync_edge.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | i2c_sync_edge : synchronizer, optional majority filter              |
// | (I2C_TARGET_GLITCH_FILTER_EN), rise/fall detect. Rev 1.0             |
// +----------------------------------------------------------------------+
module i2c_sync_edge import i2c_pkg::*; #(
  parameter int SYNC_STAGES = 2
) (
  input  wire  clk,
  input  wire  rst,
  input  wire  i_in,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_sync;
  logic                   w_level;
  logic                   r_prev;

  // Flops preset high so an idle bus produces no edges after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= '1;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_in};
    end
  end

  assign w_sync = r_sync[SYNC_STAGES-1];

`ifdef I2C_TARGET_GLITCH_FILTER_EN
  logic [1:0] r_win;
  logic       r_filt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_win  <= '1;
      r_filt <= 1'b1;
    end else begin
      r_win  <= {r_win[0], w_sync};
      r_filt <= maj3({r_win, w_sync});
    end
  end

  assign w_level = r_filt;
`else
  assign w_level = w_sync;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prev <= 1'b1;
    end else begin
      r_prev <= w_level;
    end
  end

  assign o_level = w_level;
  assign o_rise  = w_level & ~r_prev;
  assign o_fall  = ~w_level & r_prev;

endmodule
`default_nettype wire

// File: rtl/i2c_target_rx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | i2c_target_rx : write-only I2C target receiver with ACK generation   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module i2c_target_rx import i2c_pkg::*; #(
  parameter logic [I2C_ADDR_W-1:0] DEV_ADDR    = I2C_DEFAULT_ADDR,
  parameter int                    SYNC_STAGES = 2
) (
  input wire             clk,
  input wire             rst,
  i2c_target_rx_if.slave bus
);

  logic w_scl_lvl, w_scl_rise, w_scl_fall;
  logic w_sda_lvl, w_sda_rise, w_sda_fall;
  logic w_start, w_stop;
  logic [7:0] w_byte;

  i2c_state_e r_state, w_state_nxt;
  logic [2:0] r_cnt, w_cnt_nxt;
  logic [6:0] r_shift, w_shift_nxt;
  logic       r_oe, w_oe_nxt;
  logic       r_hit, w_hit_nxt;
  logic       r_busy, w_busy_nxt;
  logic [7:0] r_data, w_data_nxt;
  logic       r_valid, w_valid_nxt;

  i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_scl_sync (
    .clk     (clk),
    .rst     (rst),
    .i_in    (bus.scl),
    .o_level (w_scl_lvl),
    .o_rise  (w_scl_rise),
    .o_fall  (w_scl_fall)
  );

  i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sda_sync (
    .clk     (clk),
    .rst     (rst),
    .i_in    (bus.sda_in),
    .o_level (w_sda_lvl),
    .o_rise  (w_sda_rise),
    .o_fall  (w_sda_fall)
  );

  assign w_start = w_sda_fall & w_scl_lvl;
  assign w_stop  = w_sda_rise & w_scl_lvl;
  assign w_byte  = {r_shift, w_sda_lvl};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= 3'd0;
      r_shift <= 7'd0;
      r_oe    <= 1'b0;
      r_hit   <= 1'b0;
      r_busy  <= 1'b0;
      r_data  <= 8'h00;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_shift <= w_shift_nxt;
      r_oe    <= w_oe_nxt;
      r_hit   <= w_hit_nxt;
      r_busy  <= w_busy_nxt;
      r_data  <= w_data_nxt;
      r_valid <= w_valid_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_shift_nxt = r_shift;
    w_oe_nxt    = r_oe;
    w_hit_nxt   = r_hit;
    w_busy_nxt  = r_busy;
    w_data_nxt  = r_data;
    w_valid_nxt = 1'b0;

    if (w_stop) begin
      w_state_nxt = IDLE;
      w_cnt_nxt   = 3'd0;
      w_oe_nxt    = 1'b0;
      w_hit_nxt   = 1'b0;
      w_busy_nxt  = 1'b0;
    end else if (w_start) begin
      w_state_nxt = ADDR;
      w_cnt_nxt   = 3'd0;
      w_oe_nxt    = 1'b0;
      w_hit_nxt   = 1'b0;
      w_busy_nxt  = 1'b1;
    end else begin
      case (r_state)
        ADDR: begin
          if (w_scl_rise) begin
            w_shift_nxt = w_byte[6:0];
            w_cnt_nxt   = r_cnt + 3'd1;
            if (r_cnt == 3'd7) begin
              if (addr_write_hit(w_byte, DEV_ADDR)) begin
                w_state_nxt = ADDR_ACK;
                w_hit_nxt   = 1'b1;
              end else begin
                w_state_nxt = IGNORE;
              end
            end
          end
        end
        // First falling edge starts the ACK pulse, the second (after the
        // 9th clock) ends it and hands the bus back to the master.
        ADDR_ACK, DATA_ACK: begin
          if (w_scl_fall) begin
            if (!r_oe) begin
              w_oe_nxt = 1'b1;
            end else begin
              w_oe_nxt    = 1'b0;
              w_state_nxt = DATA;
              w_cnt_nxt   = 3'd0;
            end
          end
        end
        DATA: begin
          if (w_scl_rise) begin
            w_shift_nxt = w_byte[6:0];
            w_cnt_nxt   = r_cnt + 3'd1;
            if (r_cnt == 3'd7) begin
              w_data_nxt  = w_byte;
              w_valid_nxt = 1'b1;
              w_state_nxt = DATA_ACK;
            end
          end
        end
        default: begin
          w_oe_nxt = 1'b0;
        end
      endcase
    end
  end

  assign bus.sda_oe   = r_oe;
  assign bus.rx_data  = r_data;
  assign bus.rx_valid = r_valid;
  assign bus.addr_hit = r_hit;
  assign bus.busy     = r_busy;

endmodule
`default_nettype wire
